// File: rtl/heatmap_cell_writer.sv
// Purpose: expands heat-map cell updates (requesters A/B, plus a full-screen clear) into RGB565 pixel writes.
// Latency: first write 2 cycles after accept; an unstalled cell returns to IDLE CELL*CELL+2 cycles after accept.
// Backpressure: x_ready only pulses in IDLE; m_waitrequest holds address/data and stalls the pixel walk.
module heatmap_cell_writer #(
    parameter int          CELL      = 8,
    parameter int          GRID_COLS = 80,
    parameter int          GRID_ROWS = 60,
    parameter logic [31:0] PIX_BASE  = 32'h0000_0000,
    parameter int          Y_SHIFT   = 11,
    parameter logic [7:0]  CLEAR_VAL = 8'd0
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [6:0]  a_col,
    input  logic [5:0]  a_row,
    input  logic [7:0]  a_val,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [6:0]  b_col,
    input  logic [5:0]  b_row,
    input  logic [7:0]  b_val,
    input  logic        clear_req,
    output logic [31:0] m_address,
    output logic        m_write,
    output logic [15:0] m_writedata,
    input  logic        m_waitrequest,
    output logic        busy,
    output logic [15:0] cells_done,
    output logic [7:0]  err_count
);

    localparam int           PW       = $clog2(CELL);
    localparam logic [PW-1:0] PX_LAST = PW'(CELL - 1);
    localparam logic [6:0]   COL_LIM  = 7'(GRID_COLS);
    localparam logic [6:0]   COL_LAST = 7'(GRID_COLS - 1);
    localparam logic [5:0]   ROW_LIM  = 6'(GRID_ROWS);
    localparam logic [5:0]   ROW_LAST = 6'(GRID_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE} state_t;

    state_t          state, state_nxt;
    logic            rr_b;          // 1: B has round-robin priority
    logic            clr_pend;
    logic            clr_mode;
    logic [6:0]      col_q;
    logic [5:0]      row_q;
    logic [7:0]      val_q;
    logic [15:0]     color_q;
    logic [6+PW:0]   x0_q;
    logic [5+PW:0]   y0_q;
    logic [PW-1:0]   px_q, py_q;
    logic [15:0]     cells_done_q;
    logic [7:0]      err_q;

    logic            grant_clr;
    logic            pix_done;
    logic            cell_end;
    logic            out_of_range;
    logic [31:0]     x_pix, y_pix;

    // Heat value to RGB565: red rises with heat, blue falls, green peaks mid-scale.
    function automatic logic [15:0] heat_color(input logic [7:0] v);
        logic [5:0] g;
        g = v[7] ? ~v[6:1] : v[6:1];
        return {v[7:3], g, ~v[7:3]};
    endfunction

    assign out_of_range = (col_q >= COL_LIM) || (row_q >= ROW_LIM);
    assign x_pix        = 32'(x0_q) + 32'(px_q);
    assign y_pix        = 32'(y0_q) + 32'(py_q);
    assign m_address    = (state == S_WRITE) ? PIX_BASE + (y_pix << Y_SHIFT) + (x_pix << 1) : 32'd0;
    assign m_writedata  = (state == S_WRITE) ? color_q : 16'd0;
    assign busy         = (state != S_IDLE) || clr_pend;
    assign cells_done   = cells_done_q;
    assign err_count    = err_q;

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state, grants and Avalon strobe.
    always_comb begin
        state_nxt = state;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        grant_clr = 1'b0;
        m_write   = 1'b0;
        pix_done  = 1'b0;
        cell_end  = 1'b0;
        case (state)
            S_IDLE: begin
                if (clr_pend) begin
                    grant_clr = 1'b1;
                    state_nxt = S_LOAD;
                end else if (a_valid && (!rr_b || !b_valid)) begin
                    a_ready   = 1'b1;
                    state_nxt = S_LOAD;
                end else if (b_valid) begin
                    b_ready   = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = (!clr_mode && out_of_range) ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                m_write = 1'b1;
                if (!m_waitrequest) begin
                    pix_done = 1'b1;
                    if (px_q == PX_LAST && py_q == PX_LAST) begin
                        cell_end = 1'b1;
                        // A sweep loops back through LOAD until the last cell is painted.
                        if (clr_mode && !(col_q == COL_LAST && row_q == ROW_LAST))
                            state_nxt = S_LOAD;
                        else
                            state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latching, pixel walk, clear bookkeeping and counters.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rr_b         <= 1'b0;
            clr_pend     <= 1'b0;
            clr_mode     <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            val_q        <= '0;
            color_q      <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            px_q         <= '0;
            py_q         <= '0;
            cells_done_q <= '0;
            err_q        <= '0;
        end else begin
            // A request during a sweep or while one is queued collapses into it.
            if (clear_req && !clr_mode && !clr_pend)
                clr_pend <= 1'b1;
            if (grant_clr) begin
                clr_pend <= 1'b0;
                clr_mode <= 1'b1;
                col_q    <= '0;
                row_q    <= '0;
                val_q    <= CLEAR_VAL;
            end
            if (a_ready) begin
                col_q <= a_col;
                row_q <= a_row;
                val_q <= a_val;
                rr_b  <= 1'b1;
            end
            if (b_ready) begin
                col_q <= b_col;
                row_q <= b_row;
                val_q <= b_val;
                rr_b  <= 1'b0;
            end
            if (state == S_LOAD) begin
                if (!clr_mode && out_of_range) begin
                    if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                end else begin
                    color_q <= heat_color(val_q);
                    x0_q    <= {col_q, {PW{1'b0}}};
                    y0_q    <= {row_q, {PW{1'b0}}};
                    px_q    <= '0;
                    py_q    <= '0;
                end
            end
            if (pix_done) begin
                px_q <= px_q + 1'b1;
                if (px_q == PX_LAST) py_q <= py_q + 1'b1;
            end
            if (cell_end) begin
                if (clr_mode) begin
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        row_q <= row_q + 6'd1;
                        if (row_q == ROW_LAST) begin
                            clr_mode     <= 1'b0;
                            cells_done_q <= cells_done_q + 16'd1;
                        end
                    end else begin
                        col_q <= col_q + 7'd1;
                    end
                end else begin
                    cells_done_q <= cells_done_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_heatmap_cell_writer.sv
module tb_heatmap_cell_writer;

    localparam int CELL = 8;
    localparam int COLS = 8;   // reduced grid so a full sweep stays short
    localparam int ROWS = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [6:0]  a_col, b_col;
    logic [5:0]  a_row, b_row;
    logic [7:0]  a_val, b_val;
    logic        clear_req;
    logic [31:0] m_address;
    logic        m_write;
    logic [15:0] m_writedata;
    logic        m_waitrequest;
    logic        busy;
    logic [15:0] cells_done;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    heatmap_cell_writer #(
        .CELL(CELL), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
        .PIX_BASE(32'h0), .Y_SHIFT(11), .CLEAR_VAL(8'd0)
    ) dut (
        .CLOCK_50(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_col(a_col), .a_row(a_row), .a_val(a_val),
        .b_valid(b_valid), .b_ready(b_ready), .b_col(b_col), .b_row(b_row), .b_val(b_val),
        .clear_req(clear_req),
        .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
        .m_waitrequest(m_waitrequest),
        .busy(busy), .cells_done(cells_done), .err_count(err_count)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          a_rdy_n = 0;
    logic [31:0] last_addr = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_color(input logic [7:0] v);
        logic [4:0] r, b;
        logic [5:0] g;
        r = v[7:3];
        b = 5'd31 - v[7:3];
        g = v[7] ? 6'(63 - int'(v[6:1])) : v[6:1];
        return {r, g, b};
    endfunction

    task automatic push_cell(input int col, input int row, input logic [7:0] v);
        wr_t w;
        for (int py = 0; py < CELL; py++) begin
            for (int px = 0; px < CELL; px++) begin
                w.addr = 32'(((row * CELL + py) * 2048) + (col * CELL + px) * 2);
                w.data = model_color(v);
                sb.push_back(w);
            end
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) if (a_ready === 1'b1) a_rdy_n++;

    // Scoreboard: every write cycle must match the queue head; a completed write pops it.
    always @(negedge clk) begin
        if (m_write === 1'b1) begin
            check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                check("wr_addr", m_address, sb[0].addr);
                check("wr_data", 32'(m_writedata), 32'(sb[0].data));
                if (m_waitrequest === 1'b0) begin
                    void'(sb.pop_front());
                    wr_count++;
                    last_addr = m_address;
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits for its ready, drops valid; acc = accept cycle.
    task automatic request(input bit use_b, input int col, input int row,
                           input logic [7:0] v, output int acc);
        bit got;
        step();
        if (use_b) begin b_valid = 1'b1; b_col = 7'(col); b_row = 6'(row); b_val = v; end
        else       begin a_valid = 1'b1; a_col = 7'(col); a_row = 6'(row); a_val = v; end
        got = 1'b0;
        acc = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if ((use_b ? b_ready : a_ready) === 1'b1) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        check(use_b ? "b_ready_seen" : "a_ready_seen", 32'(got), 32'd1);
        if (got && col < COLS && row < ROWS) push_cell(col, row, v);
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int idle_cyc);
        bit done;
        done = 1'b0;
        idle_cyc = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                done = 1'b1;
                idle_cyc = cyc;
            end
        end
        check("idle_reached", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, idle, w0, r0, k;
        int exp_order[4];
        int got_order[4];
        bit a_more, b_more;

        reset_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_col = '0; a_row = '0; a_val = '0; b_col = '0; b_row = '0; b_val = '0;
        clear_req = 1'b0; m_waitrequest = 1'b0;
        #23;
        check("rst_m_write", 32'(m_write), 32'd0);
        check("rst_m_address", m_address, 32'd0);
        check("rst_m_writedata", 32'(m_writedata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cells_done", 32'(cells_done), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        step();
        reset_n = 1'b1;

        // 1: single unstalled cell from A.
        w0 = wr_count; r0 = a_rdy_n;
        request(1'b0, 0, 0, 8'd255, acc);
        @(negedge clk);
        check("t1_no_write_c1", 32'(m_write), 32'd0);
        @(negedge clk);
        check("t1_first_write_c2", 32'(m_write), 32'd1);
        check("t1_first_addr", m_address, 32'h0);
        check("t1_first_data", 32'(m_writedata), 32'hF800);
        wait_idle(500, idle);
        check("t1_cycles_to_idle", 32'(idle - acc), 32'd66);
        check("t1_a_ready_pulses", 32'(a_rdy_n - r0), 32'd1);
        check("t1_writes", 32'(wr_count - w0), 32'd64);
        check("t1_last_addr", last_addr, 32'h380E);
        check("t1_cells_done", 32'(cells_done), 32'd1);

        // 2: B cell with a 3-cycle stall on pixel (1,1).
        w0 = wr_count;
        request(1'b1, 1, 1, 8'd128, acc);
        while (cyc < acc + 11) step();
        m_waitrequest = 1'b1;
        for (int s = 0; s < 4; s++) begin
            if (s == 3) begin step(); m_waitrequest = 1'b0; end
            else if (s > 0) step();
            @(negedge clk);
            check("t2_stall_write", 32'(m_write), 32'd1);
            check("t2_stall_addr", m_address, 32'h4812);
            check("t2_stall_data", 32'(m_writedata), 32'h87EF);
        end
        wait_idle(500, idle);
        check("t2_cycles_to_idle", 32'(idle - acc), 32'd69);
        check("t2_writes", 32'(wr_count - w0), 32'd64);
        check("t2_cells_done", 32'(cells_done), 32'd2);

        // 3: A and B both valid; round-robin alternates.
        exp_order = '{0, 1, 0, 1};
        step();
        a_valid = 1'b1; a_col = 7'd2; a_row = 6'd0; a_val = 8'h40;
        b_valid = 1'b1; b_col = 7'd4; b_row = 6'd0; b_val = 8'hC3;
        a_more = 1'b0; b_more = 1'b0; k = 0;
        for (int i = 0; i < 2000 && k < 4; i++) begin
            @(negedge clk);
            if (a_ready === 1'b1 || b_ready === 1'b1) begin
                got_order[k] = (b_ready === 1'b1) ? 1 : 0;
                if (b_ready === 1'b1) push_cell(int'(b_col), int'(b_row), b_val);
                else                  push_cell(int'(a_col), int'(a_row), a_val);
                k++;
                step();
                if (got_order[k-1] == 0) begin
                    if (a_more) a_valid = 1'b0;
                    else begin a_col = 7'd3; a_val = 8'h7F; a_more = 1'b1; end
                end else begin
                    if (b_more) b_valid = 1'b0;
                    else begin b_col = 7'd5; b_val = 8'h01; b_more = 1'b1; end
                end
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("t3_grant_count", 32'(k), 32'd4);
        for (int g = 0; g < 4; g++) check("t3_grant_order", 32'(got_order[g]), 32'(exp_order[g]));
        wait_idle(500, idle);
        check("t3_sb_empty", 32'(sb.size()), 32'd0);
        check("t3_cells_done", 32'(cells_done), 32'd6);

        // 4: clear requested mid-cell; repeated requests are absorbed.
        w0 = wr_count;
        request(1'b0, 0, 2, 8'd10, acc);
        for (int i = 0; i < 10; i++) step();
        clear_req = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) push_cell(c, r, 8'd0);
        step(); clear_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        clear_req = 1'b1; step(); clear_req = 1'b0;
        check("t4_busy_pending", 32'(busy), 32'd1);
        while (cyc < acc + 300) step();
        clear_req = 1'b1; step(); clear_req = 1'b0;
        wait_idle(6000, idle);
        check("t4_writes", 32'(wr_count - w0), 32'(64 + COLS * ROWS * 64));
        check("t4_last_addr", last_addr, 32'h1787E);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        check("t4_cells_done", 32'(cells_done), 32'd8);
        for (int i = 0; i < 5; i++) step();
        check("t4_stays_idle", 32'(busy), 32'd0);

        // 5: out-of-range column, then out-of-range row.
        w0 = wr_count;
        request(1'b0, 80, 3, 8'd99, acc);
        @(negedge clk);
        check("t5_busy_load", 32'(busy), 32'd1);
        @(negedge clk);
        check("t5_idle_after_2", 32'(busy), 32'd0);
        check("t5_err_count", 32'(err_count), 32'd1);
        request(1'b1, 3, ROWS, 8'd99, acc);
        wait_idle(50, idle);
        check("t5_row_idle", 32'(idle - acc), 32'd2);
        check("t5_err_count2", 32'(err_count), 32'd2);
        check("t5_no_writes", 32'(wr_count - w0), 32'd0);
        check("t5_cells_done", 32'(cells_done), 32'd8);

        // 6: asynchronous reset while writing, then a fresh cell.
        request(1'b0, 0, 0, 8'd255, acc);
        for (int i = 0; i < 20; i++) step();
        @(negedge clk);
        #2;
        check("t6_pre_write", 32'(m_write), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_async_m_write", 32'(m_write), 32'd0);
        check("t6_cells_done", 32'(cells_done), 32'd0);
        check("t6_err_count", 32'(err_count), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        sb.delete();
        step(); step();
        reset_n = 1'b1;
        w0 = wr_count;
        request(1'b0, 0, 0, 8'd255, acc);
        wait_idle(500, idle);
        check("t6_cycles_to_idle", 32'(idle - acc), 32'd66);
        check("t6_writes", 32'(wr_count - w0), 32'd64);
        check("t6_last_addr", last_addr, 32'h380E);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        check("t6_cells_done_after", 32'(cells_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
